// File: rtl/grf_writeback_pkg.sv
// rtl/grf_writeback_pkg.sv - shared widths, trace depth default and trace record type
package grf_writeback_pkg;

    localparam int unsigned GRF_ADDR_W      = 5;
    localparam int unsigned GRF_DATA_W      = 32;
    localparam int unsigned GRF_TRACE_DEPTH = 4;

    typedef struct packed {
        logic [GRF_DATA_W-1:0] pc;
        logic [GRF_ADDR_W-1:0] addr;
        logic [GRF_DATA_W-1:0] data;
    } trace_rec_t;

endpackage

// File: rtl/grf_writeback_if.sv
// rtl/grf_writeback_if.sv - writeback, read-port and trace signals bundled for the register file
interface grf_writeback_if;
    import grf_writeback_pkg::*;

    logic                  W_RegWrite;
    logic [GRF_ADDR_W-1:0] W_RegAddr;
    logic [GRF_DATA_W-1:0] W_RegData;
    logic [GRF_DATA_W-1:0] W_PC;
    logic [GRF_ADDR_W-1:0] rs_addr;
    logic [GRF_ADDR_W-1:0] rt_addr;
    logic [GRF_DATA_W-1:0] rs_data;
    logic [GRF_DATA_W-1:0] rt_data;
    logic                  trace_valid;
    logic                  trace_ready;
    logic [GRF_DATA_W-1:0] trace_pc;
    logic [GRF_ADDR_W-1:0] trace_addr;
    logic [GRF_DATA_W-1:0] trace_data;
    logic                  trace_overflow;

    modport master (
        output W_RegWrite, W_RegAddr, W_RegData, W_PC, rs_addr, rt_addr, trace_ready,
        input  rs_data, rt_data, trace_valid, trace_pc, trace_addr, trace_data, trace_overflow
    );

    modport slave (
        input  W_RegWrite, W_RegAddr, W_RegData, W_PC, rs_addr, rt_addr, trace_ready,
        output rs_data, rt_data, trace_valid, trace_pc, trace_addr, trace_data, trace_overflow
    );

endinterface

// File: rtl/grf_trace_fifo.sv
// rtl/grf_trace_fifo.sv - writeback trace FIFO with drop-on-full and sticky overflow flag
module grf_trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         rec_t = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  rec_t push_rec_i,
    input  logic pop_ready_i,
    output logic valid_o,
    output rec_t head_o,
    output logic overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rec_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic full;
    logic do_pop;
    logic do_push;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign valid_o = (count_q != '0);
    assign do_pop  = valid_o & pop_ready_i;
    // A pop in the same edge frees the slot, so a full FIFO still accepts the push
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && full && !do_pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem_q[wr_ptr_q] <= push_rec_i;
    end

    assign head_o     = valid_o ? mem_q[rd_ptr_q] : '0;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/grf_writeback.sv
// rtl/grf_writeback.sv - 32x32 register file with same-cycle write bypass and writeback trace
module grf_writeback
    import grf_writeback_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = GRF_TRACE_DEPTH
) (
    input  logic clk,
    input  logic reset,
    grf_writeback_if.slave bus
);

    logic [GRF_DATA_W-1:0] regs_q [32];
    logic                  wr_eff;
    trace_rec_t            push_rec;
    trace_rec_t            head;

    assign wr_eff = bus.W_RegWrite && (bus.W_RegAddr != '0);

    // Register 0 is cleared by reset and never written, so it always reads as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wr_eff) begin
            regs_q[bus.W_RegAddr] <= bus.W_RegData;
        end
    end

    assign bus.rs_data = (bus.rs_addr == '0) ? '0 :
                         (wr_eff && bus.rs_addr == bus.W_RegAddr) ? bus.W_RegData :
                         regs_q[bus.rs_addr];
    assign bus.rt_data = (bus.rt_addr == '0) ? '0 :
                         (wr_eff && bus.rt_addr == bus.W_RegAddr) ? bus.W_RegData :
                         regs_q[bus.rt_addr];

    always_comb begin
        push_rec      = '0;
        push_rec.pc   = bus.W_PC;
        push_rec.addr = bus.W_RegAddr;
        push_rec.data = bus.W_RegData;
    end

    grf_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .rec_t (trace_rec_t)
    ) u_trace_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (wr_eff),
        .push_rec_i  (push_rec),
        .pop_ready_i (bus.trace_ready),
        .valid_o     (bus.trace_valid),
        .head_o      (head),
        .overflow_o  (bus.trace_overflow)
    );

    assign bus.trace_pc   = head.pc;
    assign bus.trace_addr = head.addr;
    assign bus.trace_data = head.data;

endmodule

// File: tb/tb_grf_writeback.sv
// tb/tb_grf_writeback.sv - randomized self-checking bench for grf_writeback against a queue model
module tb_grf_writeback;
    import grf_writeback_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    grf_writeback_if bus();

    grf_writeback #(.TRACE_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [32];
    trace_rec_t  m_q [$];
    logic        m_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.W_RegWrite && bus.W_RegAddr == a) return bus.W_RegData;
        return m_regs[a];
    endfunction

    task automatic check_outputs();
        trace_rec_t h;
        h = (m_q.size() != 0) ? m_q[0] : '0;
        chk("rs_data", bus.rs_data, m_read(bus.rs_addr));
        chk("rt_data", bus.rt_data, m_read(bus.rt_addr));
        chk("trace_valid", bus.trace_valid, m_q.size() != 0);
        chk("trace_pc", bus.trace_pc, h.pc);
        chk("trace_addr", bus.trace_addr, h.addr);
        chk("trace_data", bus.trace_data, h.data);
        chk("trace_overflow", bus.trace_overflow, m_ovf);
    endtask

    task automatic model_clock();
        bit eff, pop, full;
        trace_rec_t r;
        eff  = bus.W_RegWrite && bus.W_RegAddr != 5'd0;
        pop  = (m_q.size() != 0) && bus.trace_ready;
        full = (m_q.size() == DEPTH);
        if (eff && full && !pop) m_ovf = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (eff && (!full || pop)) begin
            r.pc = bus.W_PC; r.addr = bus.W_RegAddr; r.data = bus.W_RegData;
            m_q.push_back(r);
        end
        if (eff) m_regs[bus.W_RegAddr] = bus.W_RegData;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [4:0] ra, input logic [4:0] rb,
                         input logic rdy);
        bus.W_RegWrite = we; bus.W_RegAddr = wa; bus.W_RegData = wd; bus.W_PC = pc;
        bus.rs_addr = ra; bus.rt_addr = rb; bus.trace_ready = rdy;
    endtask

    // Called at negedge+1 with inputs already driven
    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [4:0] ra, input logic [4:0] rb,
                         input logic rdy);
        drive(we, wa, wd, pc, ra, rb, rdy);
        #1;
        tick();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cycle(0, 0, 0, 0, 5, 31, 0);

        // Write then read back next cycle, trace pops the record
        cycle(1, 5, 32'h12345678, 32'h0000_0100, 0, 0, 0);
        drive(0, 0, 0, 0, 5, 5, 1);
        #1;
        chk("t035_rs", bus.rs_data, 32'h12345678);
        chk("t035_pc", bus.trace_pc, 32'h0000_0100);
        chk("t035_addr", bus.trace_addr, 5'd5);
        chk("t035_data", bus.trace_data, 32'h12345678);
        tick();

        // Same-cycle bypass on both ports
        drive(1, 9, 32'hCAFEBABE, 32'h0000_0104, 9, 9, 0);
        #1;
        chk("t036_rs", bus.rs_data, 32'hCAFEBABE);
        chk("t036_rt", bus.rt_data, 32'hCAFEBABE);
        tick();
        cycle(0, 0, 0, 0, 9, 5, 1);

        // Write to register 0 is discarded and not traced
        drive(1, 0, 32'hFFFFFFFF, 32'h0000_0108, 0, 0, 0);
        #1;
        chk("t037_rs", bus.rs_data, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t037_valid", bus.trace_valid, 1'b0);
        tick();

        // Overflow: five writes into a depth-4 FIFO, drain the first four in order
        for (int i = 1; i <= 5; i++) cycle(1, 5'(i), 32'hD000_0000 + i, 32'h1000 + 4 * i, 5'(i), 0, 0);
        drive(0, 0, 0, 0, 1, 5, 0);
        #1;
        chk("t038_ovf", bus.trace_overflow, 1'b1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            #1;
            chk("t038_drain_pc", bus.trace_pc, 32'h1000 + 4 * i);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("t038_empty", bus.trace_valid, 1'b0);
        tick();

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) cycle(1, 5'(10 + i), 32'hE000_0000 + i, 32'h2000 + 4 * i, 0, 0, 0);
        cycle(1, 5'd20, 32'hE000_0044, 32'h2044, 20, 10, 1);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            #1;
            chk("t039_drain_pc", bus.trace_pc, (i == 4) ? 32'h2044 : 32'h2000 + 4 * i);
            tick();
        end

        // Asynchronous reset mid-cycle with three entries queued
        cycle(1, 7, 32'hA5A5A5A5, 32'h3000, 0, 0, 0);
        cycle(1, 8, 32'h11111111, 32'h3004, 0, 0, 0);
        cycle(1, 9, 32'h22222222, 32'h3008, 0, 0, 0);
        drive(0, 0, 0, 0, 7, 7, 0);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("t040_valid", bus.trace_valid, 1'b0);
        chk("t040_rs7", bus.rs_data, 32'd0);
        chk("t040_ovf", bus.trace_overflow, 1'b0);
        @(negedge clk);
        drive(1, 3, 32'hDEADBEEF, 32'h3010, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 3, 7, 1);

        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  (n < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
